// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory controller: FSM encoding and
// fetch sequencing limits.
package mem_ctrl_pkg;

    // Width of every byte address on the instruction/memory buses.
    localparam int INST_ADDR_W = 32;

    // Bytes gathered per instruction fetch; the byte sequencer is built around 4.
    localparam int FETCH_BYTES = 4;

    // Value of the byte counter on the last address-issuing fetch cycle.
    localparam logic [1:0] CNT_LAST = 2'(FETCH_BYTES - 1);

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,  // no fetch in progress
        ST_FETCH = 2'd1,  // issuing byte addresses base+0 .. base+3
        ST_LAST  = 2'd2,  // last byte returning, word completes this cycle
        ST_HOLD  = 2'd3   // fetch queued behind MEM-stage traffic
    } state_e;

endpackage

// File: rtl/mem_ctrl.sv
// Single-byte RAM owner. MEM-stage byte accesses pass straight through with
// absolute priority; IF-stage word fetches are sequenced as four byte reads
// in the gaps and returned as one little-endian word.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = INST_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    // MEM-stage byte port
    input  logic              mem_req_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic              mem_wr_i,
    input  logic [7:0]        mem_wdata_i,
    output logic [7:0]        mem_rdata_o,
    // IF-stage word fetch port
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_flush_i,
    output logic              if_valid_o,
    output logic [31:0]       if_inst_o,
    // RAM port
    input  logic [7:0]        ram_din_i,
    output logic [7:0]        ram_dout_o,
    output logic [ADDR_W-1:0] ram_a_o,
    output logic              ram_wr_o
);

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [2:0][7:0]   byte_q, byte_d;   // bytes 0..2; byte 3 goes straight into the word
    logic [31:0]       inst_q, inst_d;
    logic              valid_q, valid_d;

    // State register: everything freezes while rdy is low.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block evaluation order.
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            byte_q  <= '0;
            inst_q  <= '0;
            valid_q <= 1'b0;
        end else if (rdy) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            byte_q  <= byte_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
        end
    end

    // Next-state logic: flush overrides everything, MEM traffic aborts a fetch.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        byte_d  = byte_q;
        inst_d  = inst_q;
        valid_d = 1'b0;

        if (if_flush_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            if (if_req_i) begin
                base_d = if_addr_i;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (if_req_i) begin
                        base_d  = if_addr_i;
                        cnt_d   = '0;
                        state_d = mem_req_i ? ST_HOLD : ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (mem_req_i) begin
                        // Partial bytes are simply overwritten on the restart.
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end else begin
                        // The byte addressed in the previous cycle is on ram_din_i now.
                        if (cnt_q != 2'd0) begin
                            byte_d[cnt_q - 2'd1] = ram_din_i;
                        end
                        if (cnt_q == CNT_LAST) begin
                            state_d = ST_LAST;
                        end else begin
                            cnt_d = cnt_q + 2'd1;
                        end
                    end
                end
                ST_LAST: begin
                    cnt_d = '0;
                    if (mem_req_i) begin
                        state_d = ST_HOLD;
                    end else begin
                        inst_d  = {ram_din_i, byte_q};
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (!mem_req_i) begin
                        state_d = ST_FETCH;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // RAM mux: MEM stage always wins; fetch addresses only while in FETCH.
    always_comb begin
        ram_a_o    = '0;
        ram_wr_o   = 1'b0;
        ram_dout_o = '0;
        if (mem_req_i) begin
            ram_a_o    = mem_addr_i;
            ram_wr_o   = mem_wr_i & rdy;
            ram_dout_o = mem_wr_i ? mem_wdata_i : 8'h00;
        end else if (state_q == ST_FETCH) begin
            ram_a_o = base_q + ADDR_W'(cnt_q);
        end
    end

    assign mem_rdata_o = ram_din_i;
    assign if_inst_o   = inst_q;
    assign if_valid_o  = valid_q & rdy;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios followed by random
// traffic, all compared cycle by cycle against a transaction-level model.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .mem_req_i   (mem_req),
        .mem_addr_i  (mem_addr),
        .mem_wr_i    (mem_wr),
        .mem_wdata_i (mem_wdata),
        .mem_rdata_o (mem_rdata),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_flush_i  (if_flush),
        .if_valid_o  (if_valid),
        .if_inst_o   (if_inst),
        .ram_din_i   (ram_din),
        .ram_dout_o  (ram_dout),
        .ram_a_o     (ram_a),
        .ram_wr_o    (ram_wr)
    );

    // Byte RAM (low 16 address bits), one-cycle read; it shares the global stall.
    logic [7:0] ram [0:65535];
    logic [7:0] ram_q;
    assign ram_din = ram_q;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_q <= 8'h00;
        end else if (rdy) begin
            if (ram_wr) ram[ram_a[15:0]] <= ram_dout;
            ram_q <= ram[ram_a[15:0]];
        end
    end

    // Transaction-level model: one pending fetch with a progress count.
    // m_p = -1 : queued behind MEM traffic; 0..4 : clean cycles completed so far.
    logic        m_pend;
    int          m_p;
    logic [31:0] m_base;
    logic        m_vld;
    logic [31:0] m_inst;
    logic [7:0]  m_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] w;
        logic [31:0] ak;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            ak = a + 32'(k);
            w[8*k +: 8] = ram[ak[15:0]];
        end
        return w;
    endfunction

    task automatic model_reset();
        m_pend  = 1'b0;
        m_p     = 0;
        m_base  = '0;
        m_vld   = 1'b0;
        m_inst  = '0;
        m_rdata = '0;
    endtask

    // Apply one clock edge to the model, using inputs as they stood before it.
    task automatic model_edge(input logic [31:0] ea);
        logic nv;
        if (rst) begin
            model_reset();
            return;
        end
        if (!rdy) return;
        m_rdata = ram[ea[15:0]];
        nv = 1'b0;
        if (if_flush) begin
            m_pend = 1'b0;
        end else if (!m_pend) begin
            if (if_req) begin
                m_pend = 1'b1;
                m_base = if_addr;
                m_p    = mem_req ? -1 : 0;
            end
        end else if (m_p < 0) begin
            if (!mem_req) m_p = 0;
        end else if (mem_req) begin
            m_p = -1;
        end else if (m_p == 4) begin
            m_pend = 1'b0;
            nv     = 1'b1;
            m_inst = word_at(m_base);
        end else begin
            m_p++;
        end
        m_vld = nv;
    endtask

    // One clock: compare mid-cycle, then advance the model at the edge.
    task automatic cycle();
        logic [31:0] ea;
        @(negedge clk);
        if (mem_req)                          ea = mem_addr;
        else if (m_pend && m_p >= 0 && m_p <= 3) ea = m_base + 32'(m_p);
        else                                  ea = 32'h0;
        check("ram_a",     ram_a,     ea);
        check("ram_wr",    32'(ram_wr), 32'(rdy & mem_req & mem_wr));
        check("ram_dout",  32'(ram_dout), (mem_req && mem_wr) ? 32'(mem_wdata) : 32'h0);
        check("mem_rdata", 32'(mem_rdata), 32'(m_rdata));
        check("if_valid",  32'(if_valid), 32'(m_vld & rdy));
        check("if_inst",   if_inst,   m_inst);
        @(posedge clk);
        model_edge(ea);
        #1;
    endtask

    task automatic idle_inputs();
        rdy = 1'b1; mem_req = 1'b0; mem_wr = 1'b0; mem_addr = '0; mem_wdata = '0;
        if_req = 1'b0; if_flush = 1'b0; if_addr = '0;
    endtask

    task automatic start_fetch(input logic [31:0] a);
        if_req = 1'b1;
        if_addr = a;
        cycle();
        if_req = 1'b0;
    endtask

    task automatic count_valids(input int n, output int cnt, output logic [31:0] w);
        cnt = 0;
        w = '0;
        for (int i = 0; i < n; i++) begin
            cycle();
            if (if_valid) begin
                cnt++;
                w = if_inst;
            end
        end
    endtask

    task automatic rand_inputs();
        rdy       = $urandom_range(0, 9) != 0;
        mem_req   = $urandom_range(0, 4) == 0;
        mem_wr    = 1'($urandom_range(0, 1));
        mem_addr  = 32'h100 + 32'($urandom_range(0, 63));
        mem_wdata = 8'($urandom);
        if_req    = $urandom_range(0, 9) < 7;
        if_flush  = $urandom_range(0, 19) == 0;
        if_addr   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                                : 32'h100 + 32'($urandom_range(0, 63));
    endtask

    initial begin
        int          nv;
        logic [31:0] w;
        logic [7:0]  lw_exp [4];

        for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
        ram[16'h0100] = 8'h13; ram[16'h0101] = 8'h05;
        ram[16'h0102] = 8'h10; ram[16'h0103] = 8'h00;
        ram[16'h0300] = 8'hEF; ram[16'h0301] = 8'hBE;
        ram[16'h0302] = 8'hAD; ram[16'h0303] = 8'hDE;
        ram[16'hFFFE] = 8'h78; ram[16'hFFFF] = 8'h56;
        ram[16'h0000] = 8'h34; ram[16'h0001] = 8'h12;
        ram[16'h0201] = 8'h11; ram[16'h0202] = 8'h22; ram[16'h0203] = 8'h33;
        lw_exp[0] = 8'hAB; lw_exp[1] = 8'h11; lw_exp[2] = 8'h22; lw_exp[3] = 8'h33;

        idle_inputs();
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ram_a",  ram_a, 32'h0);
        check("rst_valid",  32'(if_valid), 32'h0);
        check("rst_inst",   if_inst, 32'h0);
        check("rst_rdata",  32'(mem_rdata), 32'h0);
        rst = 1'b0;
        repeat (2) cycle();

        // Uncontended fetch: valid in the cycle after the fifth edge.
        start_fetch(32'h100);
        repeat (5) cycle();
        check("fetch_valid", 32'(if_valid), 32'h1);
        check("fetch_word",  if_inst, 32'h0010_0513);
        repeat (2) cycle();

        // MEM byte store, then byte loads with one-cycle read latency.
        mem_req = 1'b1; mem_wr = 1'b1; mem_addr = 32'h200; mem_wdata = 8'hAB;
        #1;
        check("sb_wr",   32'(ram_wr), 32'h1);
        check("sb_addr", ram_a, 32'h200);
        check("sb_data", 32'(ram_dout), 32'hAB);
        cycle();
        mem_wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_addr = 32'h200 + 32'(i);
            cycle();
            check("lb_data", 32'(mem_rdata), 32'(lw_exp[i]));
        end
        idle_inputs();
        repeat (2) cycle();

        // MEM traffic on the third fetch cycle forces a full restart.
        start_fetch(32'h100);
        repeat (2) cycle();
        mem_req = 1'b1; mem_addr = 32'h10;
        repeat (2) cycle();
        mem_req = 1'b0;
        count_valids(20, nv, w);
        check("contend_cnt",  32'(nv), 32'h1);
        check("contend_word", w, 32'h0010_0513);

        // Flush redirect to 0x300 on the second fetch cycle.
        start_fetch(32'h100);
        cycle();
        if_flush = 1'b1; if_req = 1'b1; if_addr = 32'h300;
        cycle();
        if_flush = 1'b0;
        cycle();
        if_req = 1'b0;
        count_valids(15, nv, w);
        check("flush_cnt",  32'(nv), 32'h1);
        check("flush_word", w, 32'hDEAD_BEEF);

        // Three stalled cycles mid-fetch, with a write attempted during the stall.
        start_fetch(32'h100);
        repeat (2) cycle();
        rdy = 1'b0; mem_req = 1'b1; mem_wr = 1'b1; mem_addr = 32'h200; mem_wdata = 8'h55;
        #1;
        check("frz_wr", 32'(ram_wr), 32'h0);
        repeat (3) cycle();
        idle_inputs();
        repeat (3) cycle();
        check("frz_valid", 32'(if_valid), 32'h1);
        check("frz_word",  if_inst, 32'h0010_0513);
        repeat (2) cycle();

        // Fetch address wraps past the top of the address space.
        start_fetch(32'hFFFF_FFFE);
        repeat (5) cycle();
        check("wrap_valid", 32'(if_valid), 32'h1);
        check("wrap_word",  if_inst, 32'h1234_5678);
        repeat (2) cycle();

        // Asynchronous reset mid-fetch: everything clears, no late valid.
        start_fetch(32'h100);
        repeat (2) cycle();
        #3 rst = 1'b1;
        #1;
        check("arst_ram_a", ram_a, 32'h0);
        check("arst_wr",    32'(ram_wr), 32'h0);
        check("arst_dout",  32'(ram_dout), 32'h0);
        check("arst_valid", 32'(if_valid), 32'h0);
        check("arst_inst",  if_inst, 32'h0);
        check("arst_rdata", 32'(mem_rdata), 32'h0);
        model_reset();
        repeat (2) cycle();
        rst = 1'b0;
        count_valids(10, nv, w);
        check("arst_novalid", 32'(nv), 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            cycle();
        end
        idle_inputs();
        repeat (10) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
